countdown_timer: RTL and testbench
==================================

# countdown_timer

MM:SS down-counter for the digital clock's timer mode, counting from a loaded preset to 00:00. It runs in the opposite direction to the up-counting time digits: borrows ripple from seconds-ones up to minutes-tens where the clock chain propagates carries. A small FSM (IDLE/RUN/PAUSE/DONE) handles start, pause, resume and the expiry alarm. Outputs are BCD digits in the same widths as the clock digits, so the existing display path can show either source.

## Interface
- No parameters. Digit ranges are fixed at 0..59:59.
- clkmain  in  1  system clock; all state changes on its rising edge
- clear_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle 1 Hz enable pulse; one decrement per tick while in RUN
- load  in  1  one-cycle pulse; copies the preset digits into the count
- start  in  1  one-cycle pulse; run or resume
- stop  in  1  one-cycle pulse; pause, cancel or acknowledge
- preset_min_tens  in  3  preset minutes tens digit, 0..5
- preset_min_ones  in  4  preset minutes ones digit, 0..9
- preset_sec_tens  in  3  preset seconds tens digit, 0..5
- preset_sec_ones  in  4  preset seconds ones digit, 0..9
- min_tens  out  3  current count, minutes tens
- min_ones  out  4  current count, minutes ones
- sec_tens  out  3  current count, seconds tens
- sec_ones  out  4  current count, seconds ones
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
- done  out  1  one-cycle pulse on expiry
- alarm  out  1  level; high while in DONE

## Operation
- **Reset (clear_n=0):** all digits, the shadow preset, done and alarm are 0; state is IDLE. Reset takes effect immediately and aborts any operation in progress.
- **Priority each cycle:** load > stop > start > tick. Only the highest-priority event that is legal in the current state takes effect.
- **load:**
  - Legal in IDLE, PAUSE and DONE; ignored in RUN.
  - Clamps out-of-range preset digits before use: tens >5 become 5, ones >9 become 9.
  - Writes the clamped digits to the count and to the shadow preset.
  - Next state is IDLE, and alarm clears.
- **start:**
  - IDLE or PAUSE with a nonzero count: go to RUN.
  - Count equal to 00:00, or state DONE: ignored.
- **stop:**
  - RUN: go to PAUSE.
  - PAUSE: go to IDLE; the count is held.
  - DONE: go to IDLE; alarm clears.
  - IDLE: no effect.
- **tick:** acts only in RUN when no higher-priority event is active. It is ignored in every other state.
- **Decrement with borrow:**
  - sec_ones 0 wraps to 9 and borrows from sec_tens; otherwise sec_ones decrements.
  - sec_tens 0 wraps to 5 and borrows from min_ones.
  - min_ones 0 wraps to 9 and borrows from min_tens.
  - min_tens decrements when it receives a borrow.
- **Expiry:** a tick applied at 00:01 sets the count to 00:00, moves state to DONE and asserts done for exactly one cycle.
- **Defensive case:** if RUN is ever entered with a count of 00:00, the next tick goes to DONE without decrementing, and the count never underflows.

## Timing
- All outputs are registered. A digit update appears one clkmain edge after the cycle in which tick was sampled high.
- done is high during the cycle that follows the expiring edge, then low.
- alarm rises on the same edge as state becomes DONE.
- Same-cycle conflicts:
  - start and tick together in IDLE or PAUSE: enter RUN with no decrement; the first decrement comes on the next tick.
  - stop and tick together in RUN: go to PAUSE with no decrement.
  - load and start together in IDLE: the load is applied and start is dropped; start must be pulsed again.
- Back-to-back ticks on consecutive cycles each decrement by one; no minimum spacing is required.

## Configuration
- **COUNTDOWN_AUTORELOAD_EN defined:**
  - On expiry, the count reloads from the shadow preset instead of holding at 00:00.
  - State stays RUN and the done pulse is still generated.
  - alarm stays 0 and DONE is unreachable.
  - A shadow preset of 00:00 still goes to DONE, so the timer never reloads zero indefinitely.
- **Undefined:** expiry behaviour is exactly as described under Operation.

## Test plan
- **Reset:** clear_n=0 mid-RUN at 12:34 → all digits 0, state=IDLE, done=0, alarm=0, with no clock edge needed.
- **Borrow chain:** load 10:00, start, 1 tick → 09:59; load 01:00, start, 1 tick → 00:59.
- **Expiry:**
  - load 00:02, start, 2 ticks → 00:00, state=DONE, done high for exactly 1 cycle, alarm=1.
  - Further ticks leave the count at 00:00.
  - stop → IDLE and alarm=0.
- **Pause and conflicts:**
  - RUN at 00:30 with stop and tick in the same cycle → PAUSE at 00:30.
  - start together with tick → RUN at 00:30; the next tick gives 00:29.
  - load during RUN is ignored.
- **Clamp and guards:** preset digits 7,15,6,12 → count loads as 59:59; start with count 00:00 → stays IDLE.
- **With COUNTDOWN_AUTORELOAD_EN:** load 00:02, start, 2 ticks → done pulse, count reloads to 00:02, state=RUN, alarm=0.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control and digit bus of the MM:SS countdown timer.
// master drives the control pulses and preset digits; slave is the timer.
interface countdown_timer_if;
   logic       tick;
   logic       load;
   logic       start;
   logic       stop;
   logic [2:0] preset_min_tens;
   logic [3:0] preset_min_ones;
   logic [2:0] preset_sec_tens;
   logic [3:0] preset_sec_ones;
   logic [2:0] min_tens;
   logic [3:0] min_ones;
   logic [2:0] sec_tens;
   logic [3:0] sec_ones;
   logic [1:0] state;
   logic       done;
   logic       alarm;

   modport master (
      output tick, load, start, stop,
      output preset_min_tens, preset_min_ones, preset_sec_tens, preset_sec_ones,
      input  min_tens, min_ones, sec_tens, sec_ones, state, done, alarm
   );

   modport slave (
      input  tick, load, start, stop,
      input  preset_min_tens, preset_min_ones, preset_sec_tens, preset_sec_ones,
      output min_tens, min_ones, sec_tens, sec_ones, state, done, alarm
   );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS BCD down-counter with an IDLE/RUN/PAUSE/DONE control FSM.
// Event priority per cycle: load > stop > start > tick; an event that is
// illegal in the current state falls through to the next one.
// Optional build macro COUNTDOWN_AUTORELOAD_EN: on expiry the count reloads
// from the shadow preset and the timer keeps running (a zero shadow still
// ends in DONE).
module countdown_timer (
   input  logic             clkmain,
   input  logic             clear_n,
   countdown_timer_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

   // so is the LSB field, so mmss_t'(14'd1) reads as 00:01
   typedef struct packed {
      logic [2:0] mt;
      logic [3:0] mo;
      logic [2:0] st;
      logic [3:0] so;
   } mmss_t;

   state_t state_q, state_d;
   mmss_t  cnt_q, cnt_d, shadow_q, shadow_d, preset_c, cnt_dec;
   logic   done_q, done_d, alarm_q, alarm_d;
   logic   cnt_zero, cnt_one;

   assign cnt_zero = (cnt_q == '0);
   assign cnt_one  = (cnt_q == mmss_t'(14'd1));

   // Clamp out-of-range preset digits to the largest legal value
   always_comb begin
      preset_c.mt = (bus.preset_min_tens > 3'd5) ? 3'd5 : bus.preset_min_tens;
      preset_c.mo = (bus.preset_min_ones > 4'd9) ? 4'd9 : bus.preset_min_ones;
      preset_c.st = (bus.preset_sec_tens > 3'd5) ? 3'd5 : bus.preset_sec_tens;
      preset_c.so = (bus.preset_sec_ones > 4'd9) ? 4'd9 : bus.preset_sec_ones;
   end

   // One-second decrement with the borrow rippling toward minutes tens.
   // Only consumed when the count is at least 00:02, so mt never underflows.
   always_comb begin
      cnt_dec = cnt_q;
      if (cnt_q.so != 4'd0) begin
         cnt_dec.so = cnt_q.so - 4'd1;
      end else begin
         cnt_dec.so = 4'd9;
         if (cnt_q.st != 3'd0) begin
            cnt_dec.st = cnt_q.st - 3'd1;
         end else begin
            cnt_dec.st = 3'd5;
            if (cnt_q.mo != 4'd0) begin
               cnt_dec.mo = cnt_q.mo - 4'd1;
            end else begin
               cnt_dec.mo = 4'd9;
               cnt_dec.mt = cnt_q.mt - 3'd1;
            end
         end
      end
   end

   // State register
   always_ff @(posedge clkmain or negedge clear_n) begin
      if (!clear_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state, next count and expiry pulse from the prioritised events
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      done_d   = 1'b0;
      if (bus.load && state_q != RUN) begin
         cnt_d    = preset_c;
         shadow_d = preset_c;
         state_d  = IDLE;
      end else if (bus.stop && state_q != IDLE) begin
         state_d = (state_q == RUN) ? PAUSE : IDLE;
      end else if (bus.start && (state_q == IDLE || state_q == PAUSE) && !cnt_zero) begin
         state_d = RUN;
      end else if (bus.tick && state_q == RUN) begin
         if (cnt_zero || cnt_one) begin
            // 00:01 expires normally; 00:00 in RUN expires without underflow
            done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
            if (shadow_q != '0) begin
               cnt_d = shadow_q;
            end else begin
               cnt_d   = '0;
               state_d = DONE;
            end
`else
            cnt_d   = '0;
            state_d = DONE;
`endif
         end else begin
            cnt_d = cnt_dec;
         end
      end
      alarm_d = (state_d == DONE);
   end

   // Count, shadow preset and status registers
   always_ff @(posedge clkmain or negedge clear_n) begin
      if (!clear_n) begin
         cnt_q    <= '0;
         shadow_q <= '0;
         done_q   <= 1'b0;
         alarm_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         done_q   <= done_d;
         alarm_q  <= alarm_d;
      end
   end

   assign bus.min_tens = cnt_q.mt;
   assign bus.min_ones = cnt_q.mo;
   assign bus.sec_tens = cnt_q.st;
   assign bus.sec_ones = cnt_q.so;
   assign bus.state    = state_q;
   assign bus.done     = done_q;
   assign bus.alarm    = alarm_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: a seconds-based model checked every cycle,
// plus literal MM:SS expectations on directed scenarios.
// Build with COUNTDOWN_AUTORELOAD_EN defined to exercise the reload variant.
module tb_countdown_timer;
   logic clkmain = 1'b0;
   logic clear_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   countdown_timer_if bus();

   countdown_timer dut (
      .clkmain (clkmain),
      .clear_n (clear_n),
      .bus     (bus)
   );

   always #5 clkmain = ~clkmain;

   // Model: count held as plain seconds, state as 0..3
   int m_secs = 0, m_shadow = 0, m_state = 0;
   bit m_done = 0;

   function automatic int clamp(input int v, input int hi);
      return (v > hi) ? hi : v;
   endfunction

   always @(posedge clkmain or negedge clear_n) begin
      if (!clear_n) begin
         m_secs = 0; m_shadow = 0; m_state = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (bus.load && m_state != 1) begin
            m_shadow = clamp(int'(bus.preset_min_tens), 5) * 600 + clamp(int'(bus.preset_min_ones), 9) * 60
                     + clamp(int'(bus.preset_sec_tens), 5) * 10 + clamp(int'(bus.preset_sec_ones), 9);
            m_secs  = m_shadow;
            m_state = 0;
         end else if (bus.stop && m_state != 0) begin
            m_state = (m_state == 1) ? 2 : 0;
         end else if (bus.start && (m_state == 0 || m_state == 2) && m_secs != 0) begin
            m_state = 1;
         end else if (bus.tick && m_state == 1) begin
            if (m_secs <= 1) begin
               m_done = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
               if (m_shadow != 0) m_secs = m_shadow;
               else begin m_secs = 0; m_state = 3; end
`else
               m_secs = 0; m_state = 3;
`endif
            end else begin
               m_secs = m_secs - 1;
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clkmain) begin
      check("mdl_min_tens", int'(bus.min_tens), m_secs / 600);
      check("mdl_min_ones", int'(bus.min_ones), (m_secs / 60) % 10);
      check("mdl_sec_tens", int'(bus.sec_tens), (m_secs % 60) / 10);
      check("mdl_sec_ones", int'(bus.sec_ones), m_secs % 10);
      check("mdl_state",    int'(bus.state),    m_state);
      check("mdl_done",     int'(bus.done),     int'(m_done));
      check("mdl_alarm",    int'(bus.alarm),    (m_state == 3) ? 1 : 0);
   end

   task automatic lit(input string name, input int mt, input int mo, input int st, input int so, input int s);
      check({name, "_mmss"}, int'(bus.min_tens) * 1000 + int'(bus.min_ones) * 100
                             + int'(bus.sec_tens) * 10 + int'(bus.sec_ones),
            mt * 1000 + mo * 100 + st * 10 + so);
      check({name, "_state"}, int'(bus.state), s);
   endtask

   // One clock with the given pulses; returns 1 time unit after the edge
   task automatic step(input bit l, input bit sa, input bit sp, input bit tk);
      bus.load = l; bus.start = sa; bus.stop = sp; bus.tick = tk;
      @(posedge clkmain);
      #1;
      bus.load = 0; bus.start = 0; bus.stop = 0; bus.tick = 0;
   endtask

   task automatic preset(input int mt, input int mo, input int st, input int so);
      bus.preset_min_tens = 3'(mt); bus.preset_min_ones = 4'(mo);
      bus.preset_sec_tens = 3'(st); bus.preset_sec_ones = 4'(so);
   endtask

   task automatic load_mmss(input int mt, input int mo, input int st, input int so);
      preset(mt, mo, st, so);
      step(1, 0, 0, 0);
   endtask

   initial begin
      bus.load = 0; bus.start = 0; bus.stop = 0; bus.tick = 0;
      preset(0, 0, 0, 0);
      repeat (2) @(posedge clkmain);
      #1;
      lit("reset", 0, 0, 0, 0, 0);
      check("reset_alarm", int'(bus.alarm), 0);
      clear_n = 1'b1;
      step(0, 0, 0, 0);

      // Full borrow chain 10:00 -> 09:59
      load_mmss(1, 0, 0, 0);
      lit("load10", 1, 0, 0, 0, 0);
      step(0, 1, 0, 0);
      lit("start10", 1, 0, 0, 0, 1);
      step(0, 0, 0, 1);
      lit("borrow10", 0, 9, 5, 9, 1);

      // load while running is ignored
      load_mmss(0, 1, 0, 0);
      lit("load_in_run", 0, 9, 5, 9, 1);
      step(0, 0, 1, 0);
      lit("pause", 0, 9, 5, 9, 2);
      step(0, 0, 1, 0);
      lit("cancel", 0, 9, 5, 9, 0);

      // 01:00 -> 00:59
      load_mmss(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      lit("borrow01", 0, 0, 5, 9, 1);

      // Same-cycle conflicts at 00:30
      step(0, 0, 1, 0);
      load_mmss(0, 0, 3, 0);
      step(0, 1, 0, 0);
      step(0, 0, 1, 1);
      lit("stop_tick", 0, 0, 3, 0, 2);
      step(0, 1, 0, 1);
      lit("start_tick", 0, 0, 3, 0, 1);
      step(0, 0, 0, 1);
      lit("next_tick", 0, 0, 2, 9, 1);
      repeat (3) step(0, 0, 0, 1);
      lit("b2b_ticks", 0, 0, 2, 6, 1);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);

      // Expiry
      load_mmss(0, 0, 0, 2);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      lit("exp_01", 0, 0, 0, 1, 1);
      step(0, 0, 0, 1);
`ifdef COUNTDOWN_AUTORELOAD_EN
      lit("reload", 0, 0, 0, 2, 1);
      check("reload_done", int'(bus.done), 1);
      check("reload_alarm", int'(bus.alarm), 0);
      step(0, 0, 0, 0);
      check("reload_done_low", int'(bus.done), 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
`else
      lit("expire", 0, 0, 0, 0, 3);
      check("exp_done", int'(bus.done), 1);
      check("exp_alarm", int'(bus.alarm), 1);
      step(0, 0, 0, 0);
      check("exp_done_low", int'(bus.done), 0);
      step(0, 0, 0, 1);
      step(0, 1, 0, 1);
      lit("done_hold", 0, 0, 0, 0, 3);
      step(0, 0, 1, 0);
      lit("ack", 0, 0, 0, 0, 0);
      check("ack_alarm", int'(bus.alarm), 0);
`endif

      // Clamp and guards
      load_mmss(7, 15, 6, 12);
      lit("clamp", 5, 9, 5, 9, 0);
      load_mmss(0, 0, 0, 0);
      step(0, 1, 0, 0);
      lit("start_zero", 0, 0, 0, 0, 0);
      preset(0, 0, 0, 5);
      step(1, 1, 0, 0);
      lit("load_start", 0, 0, 0, 5, 0);

      // Asynchronous reset while running at 12:34
      load_mmss(1, 2, 3, 4);
      step(0, 1, 0, 0);
      lit("pre_reset", 1, 2, 3, 4, 1);
      clear_n = 1'b0;
      #2;
      lit("async_reset", 0, 0, 0, 0, 0);
      check("async_reset_done", int'(bus.done), 0);
      check("async_reset_alarm", int'(bus.alarm), 0);
      @(posedge clkmain);
      #1;
      clear_n = 1'b1;
      step(0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
